dram_responder: RTL and testbench

//  Responder (memory side) of the CPU data-RAM interface: 256x8 synchronous data RAM answering

---
 rtl/dram_responder_pkg.sv | 22 ++
 rtl/dram_responder_if.sv | 34 +++
 rtl/dram_responder_sp_sram.sv | 32 +++
 rtl/dram_responder.sv | 122 ++++++++++++
 tb/tb_dram_responder.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dram_responder_pkg.sv
// Shared host-port definitions for the data-RAM responder: command opcodes,
// host FSM states and the LEN-byte decoder.
package dram_responder_pkg;

    localparam logic [7:0] HOST_CMD_LOAD = 8'h01;
    localparam logic [7:0] HOST_CMD_DUMP = 8'h02;

    typedef enum logic [2:0] {
        S_CMD,
        S_ADDR,
        S_LEN,
        S_LOAD,
        S_DUMP_RD,
        S_DUMP_TX
    } host_state_e;

    // A LEN byte of zero requests a full 256-byte transfer.
    function automatic logic [8:0] len_to_cnt(input logic [7:0] len);
        return (len == 8'd0) ? 9'd256 : {1'b0, len};
    endfunction

endpackage

// File: rtl/dram_responder_if.sv
// CPU data-RAM bus plus the byte-stream host port of the RAM responder.
// master = CPU/host side, slave = memory responder.
interface dram_responder_if #(
    parameter int W_DATA = 8,
    parameter int W_ADDR = 8
);
    logic [W_ADDR-1:0] dram_addr;
    logic [W_DATA-1:0] dram_din;
    logic              dram_write;
    logic [W_DATA-1:0] dram_dout;
    logic              cpu_idle;
    logic              host_busy;
    logic [7:0]        host_in_data;
    logic              host_in_valid;
    logic              host_in_ready;
    logic [7:0]        host_out_data;
    logic              host_out_valid;
    logic              host_out_ready;
    logic              cmd_err;

    modport master (
        output dram_addr, dram_din, dram_write, cpu_idle,
        output host_in_data, host_in_valid, host_out_ready,
        input  dram_dout, host_busy, host_in_ready,
        input  host_out_data, host_out_valid, cmd_err
    );

    modport slave (
        input  dram_addr, dram_din, dram_write, cpu_idle,
        input  host_in_data, host_in_valid, host_out_ready,
        output dram_dout, host_busy, host_in_ready,
        output host_out_data, host_out_valid, cmd_err
    );
endinterface

// File: rtl/dram_responder_sp_sram.sv
// Single-port synchronous RAM, read-first: a write returns the old word on the
// same edge. The array is never reset; only the read register is.
module dram_responder_sp_sram #(
    parameter int W_DATA = 8,
    parameter int W_ADDR = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [W_ADDR-1:0] addr_i,
    input  logic [W_DATA-1:0] wdata_i,
    output logic [W_DATA-1:0] rdata_o
);
    logic [W_DATA-1:0] mem_q [2**W_ADDR];
    logic [W_DATA-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/dram_responder.sv
// CPU data-RAM responder with a host LOAD/DUMP byte port that owns the RAM
// (and holds off CPU writes) while a host transfer is in progress.
module dram_responder
    import dram_responder_pkg::*;
#(
    parameter int W_DATA = 8,
    parameter int W_ADDR = 8
) (
    input logic             clk,
    input logic             rst,
    dram_responder_if.slave bus
);
    host_state_e       state_q, state_d;
    logic [W_ADDR-1:0] hptr_q, hptr_d;
    logic [8:0]        cnt_q, cnt_d;
    logic              dump_q, dump_d;
    logic              stall_q, err_q, err_d;
    logic              in_fire, out_fire, stall, bad_op, cmd_ok;
    logic              in_ready, out_valid, busy;
    logic              mem_we;
    logic [W_ADDR-1:0] mem_addr;
    logic [W_DATA-1:0] mem_wdata, mem_rdata;

    assign in_fire  = bus.host_in_valid && in_ready;
    assign out_fire = out_valid && bus.host_out_ready;
    assign cmd_ok   = (bus.host_in_data == HOST_CMD_LOAD) || (bus.host_in_data == HOST_CMD_DUMP);
    assign stall    = (state_q == S_CMD) && bus.host_in_valid && !bus.cpu_idle;
    assign bad_op   = (state_q == S_CMD) && in_fire && !cmd_ok;
    // Error fires once on stall entry, not every stalled cycle.
    assign err_d    = bad_op || (stall && !stall_q) || (busy && bus.dram_write);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_CMD;
            hptr_q  <= '0;
            cnt_q   <= '0;
            dump_q  <= 1'b0;
            stall_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hptr_q  <= hptr_d;
            cnt_q   <= cnt_d;
            dump_q  <= dump_d;
            stall_q <= stall;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_CMD:     if (in_fire && cmd_ok) state_d = S_ADDR;
            S_ADDR:    if (in_fire) state_d = S_LEN;
            S_LEN:     if (in_fire) state_d = dump_q ? S_DUMP_RD : S_LOAD;
            S_LOAD:    if (in_fire && cnt_q == 9'd1) state_d = S_CMD;
            S_DUMP_RD: state_d = S_DUMP_TX;
            S_DUMP_TX: if (out_fire) state_d = (cnt_q == 9'd1) ? S_CMD : S_DUMP_RD;
            default:   state_d = S_CMD;
        endcase
    end

    always_comb begin
        hptr_d = hptr_q;
        cnt_d  = cnt_q;
        dump_d = dump_q;
        case (state_q)
            S_CMD:  if (in_fire) dump_d = (bus.host_in_data == HOST_CMD_DUMP);
            S_ADDR: if (in_fire) hptr_d = W_ADDR'(bus.host_in_data);
            S_LEN:  if (in_fire) cnt_d = len_to_cnt(bus.host_in_data);
            S_LOAD: begin
                if (in_fire) begin
                    hptr_d = hptr_q + 1'b1;
                    cnt_d  = cnt_q - 9'd1;
                end
            end
            S_DUMP_TX: begin
                if (out_fire) begin
                    hptr_d = hptr_q + 1'b1;
                    cnt_d  = cnt_q - 9'd1;
                end
            end
            default: ;
        endcase
    end

    // The RAM read register doubles as the held dump word: address and contents
    // cannot change while S_DUMP_TX waits for the host.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = (state_q != S_CMD);
        case (state_q)
            S_CMD:                 in_ready = bus.cpu_idle;
            S_ADDR, S_LEN, S_LOAD: in_ready = 1'b1;
            S_DUMP_TX:             out_valid = 1'b1;
            default: ;
        endcase
        mem_addr  = busy ? hptr_q : bus.dram_addr;
        mem_we    = busy ? ((state_q == S_LOAD) && bus.host_in_valid) : bus.dram_write;
        mem_wdata = busy ? W_DATA'(bus.host_in_data) : bus.dram_din;
    end

    dram_responder_sp_sram #(
        .W_DATA(W_DATA),
        .W_ADDR(W_ADDR)
    ) u_ram (
        .clk    (clk),
        .rst    (rst),
        .we_i   (mem_we),
        .addr_i (mem_addr),
        .wdata_i(mem_wdata),
        .rdata_o(mem_rdata)
    );

    assign bus.dram_dout      = mem_rdata;
    assign bus.host_out_data  = 8'(mem_rdata);
    assign bus.host_out_valid = out_valid;
    assign bus.host_in_ready  = in_ready;
    assign bus.host_busy      = busy;
    assign bus.cmd_err        = err_q;
endmodule

// File: tb/tb_dram_responder.sv
// Bench for dram_responder: CPU vector table, host LOAD/DUMP sequences with a
// dump-byte scoreboard, and error/reset corner cases.
module tb_dram_responder;
    import dram_responder_pkg::*;

    logic clk, rst;
    int   checks   = 0;
    int   failures = 0;
    logic rand_ready = 1'b0;
    logic hold_pend  = 1'b0;
    logic [7:0] held;
    logic [7:0] model [256];
    logic [7:0] exp_q [$];

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] din;
        logic       chk;
        logic [7:0] exp;
    } cpu_vec_t;
    cpu_vec_t vecs [8];

    dram_responder_if #(.W_DATA(8), .W_ADDR(8)) bus ();

    dram_responder #(.W_DATA(8), .W_ADDR(8)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        #1;
        bus.host_out_ready = rand_ready ? ($urandom_range(0, 1) != 0) : 1'b1;
    end

    // Dump monitor: stability while stalled, and in-order scoreboard pops.
    always @(negedge clk) begin
        if (hold_pend) begin
            check("out_hold_valid", 32'(bus.host_out_valid), 32'd1);
            check("out_hold_data", 32'(bus.host_out_data), 32'(held));
        end
        if (bus.host_out_valid && bus.host_out_ready) begin
            check("dump_queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                check("dump_byte", 32'(bus.host_out_data), 32'(exp_q.pop_front()));
            end
        end
        hold_pend <= bus.host_out_valid && !bus.host_out_ready;
        held      <= bus.host_out_data;
    end

    task automatic host_send(input logic [7:0] b);
        int n;
        n = 0;
        bus.host_in_data  = b;
        bus.host_in_valid = 1'b1;
        #1;
        while (!bus.host_in_ready && n < 50) begin
            tick();
            n++;
        end
        check("in_ready_wait", 32'(n < 50), 32'd1);
        tick();
        bus.host_in_valid = 1'b0;
    endtask

    task automatic host_load(input logic [7:0] a, input int n, input logic [7:0] seed, input logic [7:0] step);
        logic [7:0] b;
        host_send(HOST_CMD_LOAD);
        check("busy_after_cmd", 32'(bus.host_busy), 32'd1);
        host_send(a);
        host_send(8'(n));
        for (int i = 0; i < n; i++) begin
            b = seed + 8'(i) * step;
            host_send(b);
            model[a + 8'(i)] = b;
        end
        check("busy_after_load", 32'(bus.host_busy), 32'd0);
    endtask

    task automatic host_dump(input logic [7:0] a, input int n);
        int k;
        host_send(HOST_CMD_DUMP);
        host_send(a);
        for (int i = 0; i < n; i++) exp_q.push_back(model[a + 8'(i)]);
        host_send(8'(n));
        check("dump_in_ready", 32'(bus.host_in_ready), 32'd0);
        check("dump_rd_valid", 32'(bus.host_out_valid), 32'd0);
        k = 0;
        while ((exp_q.size() != 0 || bus.host_busy) && k < 5000) begin
            tick();
            k++;
        end
        check("dump_done", 32'(k < 5000), 32'd1);
        check("dump_queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic cpu_cycle(input logic we, input logic [7:0] a, input logic [7:0] d);
        bus.dram_write = we;
        bus.dram_addr  = a;
        bus.dram_din   = d;
        tick();
        bus.dram_write = 1'b0;
        if (we) model[a] = d;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.dram_addr     = 8'h00;
        bus.dram_din      = 8'h00;
        bus.dram_write    = 1'b0;
        bus.cpu_idle      = 1'b1;
        bus.host_in_data  = 8'h00;
        bus.host_in_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_dout", 32'(bus.dram_dout), 32'h0);
        check("rst_out_valid", 32'(bus.host_out_valid), 32'd0);
        check("rst_out_data", 32'(bus.host_out_data), 32'h0);
        check("rst_cmd_err", 32'(bus.cmd_err), 32'd0);
        check("rst_busy", 32'(bus.host_busy), 32'd0);
        check("rst_in_ready", 32'(bus.host_in_ready), 32'd1);
        rst = 1'b0;
        tick();

        host_load(8'h10, 4, 8'hA1, 8'h11);
        host_dump(8'h10, 4);

        vecs[0] = '{1'b1, 8'h20, 8'h5A, 1'b0, 8'h00};
        vecs[1] = '{1'b0, 8'h20, 8'h00, 1'b1, 8'h5A};
        vecs[2] = '{1'b1, 8'h21, 8'h3C, 1'b0, 8'h00};
        vecs[3] = '{1'b1, 8'h21, 8'h77, 1'b1, 8'h3C};
        vecs[4] = '{1'b0, 8'h21, 8'h00, 1'b1, 8'h77};
        vecs[5] = '{1'b0, 8'h10, 8'h00, 1'b1, 8'hA1};
        vecs[6] = '{1'b0, 8'h13, 8'h00, 1'b1, 8'hD4};
        vecs[7] = '{1'b0, 8'h20, 8'h00, 1'b1, 8'h5A};
        for (int i = 0; i < 8; i++) begin
            cpu_cycle(vecs[i].we, vecs[i].addr, vecs[i].din);
            if (vecs[i].chk) check($sformatf("cpu_vec%0d", i), 32'(bus.dram_dout), 32'(vecs[i].exp));
        end

        host_load(8'hFE, 4, 8'h11, 8'h11);
        cpu_cycle(1'b0, 8'hFE, 8'h00);
        check("wrap_fe", 32'(bus.dram_dout), 32'h11);
        cpu_cycle(1'b0, 8'hFF, 8'h00);
        check("wrap_ff", 32'(bus.dram_dout), 32'h22);
        cpu_cycle(1'b0, 8'h00, 8'h00);
        check("wrap_00", 32'(bus.dram_dout), 32'h33);
        cpu_cycle(1'b0, 8'h01, 8'h00);
        check("wrap_01", 32'(bus.dram_dout), 32'h44);
        rand_ready = 1'b1;
        host_dump(8'hFE, 4);
        rand_ready = 1'b0;

        host_send(8'h7F);
        check("badop_err", 32'(bus.cmd_err), 32'd1);
        check("badop_busy", 32'(bus.host_busy), 32'd0);
        tick();
        check("badop_err_pulse", 32'(bus.cmd_err), 32'd0);

        bus.cpu_idle      = 1'b0;
        bus.host_in_data  = HOST_CMD_LOAD;
        bus.host_in_valid = 1'b1;
        #1;
        check("stall_ready", 32'(bus.host_in_ready), 32'd0);
        tick();
        check("stall_err", 32'(bus.cmd_err), 32'd1);
        tick();
        check("stall_err_once", 32'(bus.cmd_err), 32'd0);
        check("stall_busy", 32'(bus.host_busy), 32'd0);
        bus.host_in_valid = 1'b0;
        bus.cpu_idle      = 1'b1;
        tick();
        check("stall_no_accept", 32'(bus.host_busy), 32'd0);

        // CPU drops idle and tries to write while the host owns the RAM.
        cpu_cycle(1'b1, 8'h40, 8'h12);
        host_send(HOST_CMD_LOAD);
        bus.cpu_idle   = 1'b0;
        bus.dram_write = 1'b1;
        bus.dram_addr  = 8'h40;
        bus.dram_din   = 8'hEE;
        host_send(8'h30);
        bus.dram_write = 1'b0;
        check("busy_wr_err", 32'(bus.cmd_err), 32'd1);
        host_send(8'h02);
        host_send(8'h55);
        host_send(8'h66);
        model[8'h30] = 8'h55;
        model[8'h31] = 8'h66;
        check("busy_wr_done", 32'(bus.host_busy), 32'd0);
        bus.cpu_idle = 1'b1;
        cpu_cycle(1'b0, 8'h40, 8'h00);
        check("busy_wr_ignored", 32'(bus.dram_dout), 32'h12);
        cpu_cycle(1'b0, 8'h30, 8'h00);
        check("busy_wr_load", 32'(bus.dram_dout), 32'h55);

        host_load(8'h80, 256, 8'h03, 8'h07);
        rand_ready = 1'b1;
        host_dump(8'h80, 256);
        rand_ready = 1'b0;

        host_send(HOST_CMD_LOAD);
        host_send(8'h50);
        host_send(8'h04);
        host_send(8'h61);
        host_send(8'h62);
        model[8'h50] = 8'h61;
        model[8'h51] = 8'h62;
        bus.host_in_data  = 8'h63;
        bus.host_in_valid = 1'b1;
        rst = 1'b1;
        #1;
        check("midrst_busy", 32'(bus.host_busy), 32'd0);
        check("midrst_dout", 32'(bus.dram_dout), 32'h0);
        check("midrst_out_valid", 32'(bus.host_out_valid), 32'd0);
        bus.host_in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("midrst_in_ready", 32'(bus.host_in_ready), 32'd1);
        host_dump(8'h50, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
